// File: rtl/riscv_dmem_responder.sv
// Single-port data memory responder: valid/ready request, fixed wait states, held response.
// Optional macro DMEM_MISALIGN_CHECK_EN faults accesses with addr[1:0] != 0.
module riscv_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic [1:0]  state;
    logic [3:0]  cnt;
    req_t        held;
    req_t        acc;
    logic        accept;
    logic        commit;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;

    // With zero wait states the access commits on the accept edge, so it must
    // come straight from the request port rather than the held copy.
    always_comb begin
        acc = held;
        if (state == IDLE)
            acc = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    end

    assign commit  = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == 4'd0);
    assign acc_idx = acc.addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_err = (|acc.addr[31:AW+2]) | (|acc.addr[1:0]);
`else
    // Sub-word offset is ignored; the enclosing aligned word is accessed.
    logic unused_lsb;
    assign acc_err    = |acc.addr[31:AW+2];
    assign unused_lsb = ^acc.addr[1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            held      <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    held <= acc;
                    if (WAIT_CYCLES == 0) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: if (cnt == 4'd0) state <= RESP;
                      else             cnt   <= cnt - 4'd1;
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc.we || acc_err) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // Memory is never reset; a store still waiting when rst hits is simply dropped.
    always_ff @(posedge clk) begin
        if (commit && !rst && acc.we && !acc_err) begin
            for (int i = 0; i < 4; i++)
                if (acc.be[i]) mem[acc_idx][8*i +: 8] <= acc.wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder with a word-level reference memory and per-cycle compare.
module tb_riscv_dmem_responder;
    localparam int DW = 256;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    riscv_dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word-addressed memory, one transaction in flight.
    bit [31:0]   mm [int];
    bit          run = 0;
    bit          in_flight = 0;
    bit          committed = 0;
    int          acc_cyc = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] e_rdata;
    logic        e_err;
    bit          e_known;

    function automatic bit addr_err(input logic [31:0] a);
        bit e;
        e = (a[31:2] >= DW);
`ifdef DMEM_MISALIGN_CHECK_EN
        e = e | (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    task automatic model_commit();
        int idx;
        bit [31:0] w;
        e_err = addr_err(m_addr);
        idx = int'(m_addr[31:2]);
        e_rdata = 32'd0;
        e_known = 1;
        if (m_we) begin
            if (!e_err) begin
                w = mm.exists(idx) ? mm[idx] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                mm[idx] = w;
            end
        end else if (!e_err) begin
            e_known = mm.exists(idx);
            if (e_known) e_rdata = mm[idx];
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        logic ev;
        wait (run);
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flight = 0;
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
            end else if (!in_flight) begin
                chk("idle_req_ready", req_ready, 1);
                chk("idle_rsp_valid", rsp_valid, 0);
                if (req_valid) begin
                    in_flight = 1; committed = 0; acc_cyc = cyc;
                    m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_be = req_be;
                end
            end else begin
                ev = (cyc >= acc_cyc + WC + 1);
                if (ev && !committed) begin
                    model_commit();
                    committed = 1;
                end
                chk("busy_req_ready", req_ready, 0);
                chk("rsp_valid", rsp_valid, ev);
                if (ev) begin
                    chk("rsp_err", rsp_err, e_err);
                    if (e_known) chk("rsp_rdata", rsp_rdata, e_rdata);
                    if (rsp_ready) in_flight = 0;
                end
            end
        end
    end

    // One transaction; req_* are scrambled while busy to show they are ignored.
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er, output int lat, output int acyc);
        int n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        acyc = cyc;
        @(posedge clk); #1;
        req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        req_valid = 0;
        rsp_ready = 1;
        rd = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, a1, a2;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        rst = 0;
        run = 1;
        @(posedge clk); #1;
        chk("ready_after_reset", req_ready, 1);

        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, a1);
        chk("store_latency", lat, WC + 1);
        chk("store_err", er, 0);
        chk("store_rdata", rd, 0);
        xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("load_latency", lat, WC + 1);
        chk("load_rdata", rd, 32'hDEADBEEF);
        chk("load_err", er, 0);

        xfer(1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er, lat, a1);
        xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("byte0_merge", rd, 32'hDEADBEAA);

        xfer(1, 32'h10, 32'h12345678, 4'b0000, 0, rd, er, lat, a1);
        chk("be0_err", er, 0);
        xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("be0_noop", rd, 32'hDEADBEAA);

        xfer(1, 32'h14, 32'h11223344, 4'hF, 0, rd, er, lat, a1);
        xfer(1, 32'h14, 32'hAABBCCDD, 4'b1010, 0, rd, er, lat, a1);
        xfer(0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("be1010_merge", rd, 32'hAA22CC44);

        xfer(1, 32'h0, 32'h12345678, 4'hF, 0, rd, er, lat, a1);
        xfer(1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, a1);
        chk("oob_store_err", er, 1);
        xfer(0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("oob_load_err", er, 1);
        chk("oob_load_rdata", rd, 0);
        xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("word0_intact", rd, 32'h12345678);

        xfer(1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, a1);
        xfer(0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("last_word_rdata", rd, 32'hCAFEF00D);
        chk("last_word_err", er, 0);

        xfer(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, a1);
        chk("held_rdata", rd, 32'hDEADBEAA);

        xfer(0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat, a1);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misalign_err", er, 1);
        chk("misalign_rdata", rd, 0);
`else
        chk("misalign_err", er, 0);
        chk("misalign_rdata", rd, 32'hDEADBEAA);
`endif

        xfer(0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat, a1);
        xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, a2);
        chk("throughput", a2 - a1, WC + 2);

        xfer(1, 32'h20, 32'h11111111, 4'hF, 0, rd, er, lat, a1);
        xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("pre_reset_load", rd, 32'h11111111);
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h55555555; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midop_rst_valid", rsp_valid, 0);
        chk("midop_rst_rdata", rsp_rdata, 0);
        chk("midop_rst_err", rsp_err, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("ready_after_midop_rst", req_ready, 1);
        xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, a1);
        chk("aborted_store", rd, 32'h11111111);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/riscv_dmem_responder.md
RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit memory words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables, bit i writes byte lane i.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, word-aligned.
REQ-014 SHALL have port rsp_err  output  1  access fault for this response.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid & req_ready, latching we, addr, wdata, be.
REQ-017 SHALL go IDLE->WAIT on accept when WAIT_CYCLES>0, loading a down-counter with WAIT_CYCLES-1; IDLE->RESP directly when WAIT_CYCLES=0.
REQ-018 SHALL leave WAIT for RESP on the cycle the counter is 0, else decrement; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-019 SHALL perform the memory write and capture read data on the WAIT/IDLE->RESP transition edge, word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-020 SHALL on store write only lanes with be set; be=0000 is a legal no-op store with rsp_err=0.
REQ-021 SHALL on load return the full word; rsp_rdata = 0 for stores and for errored accesses.
REQ-022 SHALL flag rsp_err=1, suppress the write and return rdata 0 when addr[31:2] >= DEPTH_WORDS.
REQ-023 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then go to IDLE on that edge.
REQ-024 SHALL not accept a new request in the RESP->IDLE cycle (req_ready rises the cycle after the handshake); back-to-back throughput = one request per WAIT_CYCLES+2 cycles.
REQ-025 SHALL ignore req_* inputs outside IDLE; changes during WAIT/RESP do not alter the in-flight access.

Reset
REQ-026 SHALL on rst asynchronously force state IDLE, counter 0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 SHALL abort an in-flight access on reset mid-operation; a store not yet committed (still in WAIT) SHALL NOT modify memory.
REQ-028 SHALL not clear memory contents on reset; contents after power-up are undefined.

Configuration
REQ-029 SHALL honour macro DMEM_MISALIGN_CHECK_EN: when defined, a request with addr[1:0] != 00 SHALL complete with rsp_err=1, no write, rdata 0.
REQ-030 SHALL, when DMEM_MISALIGN_CHECK_EN is undefined, ignore addr[1:0] and treat the access as the enclosing aligned word.

Verification
REQ-031 Store 0xDEADBEEF be=1111 to 0x10, then load 0x10, WAIT_CYCLES=2 -> each rsp_valid exactly 3 cycles after accept; load rdata=0xDEADBEEF, rsp_err=0.
REQ-032 Word 0x10 = 0xDEADBEEF, store 0x000000AA be=0001 -> load returns 0xDEADBEAA.
REQ-033 Load 0x400 with DEPTH_WORDS=256 -> rsp_err=1, rdata=0; store to 0x400 leaves word 0 unchanged.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/err stable, req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-035 Assert rst one cycle after accepting store 0x55555555 to 0x20 (WAIT_CYCLES=2) -> outputs reset immediately; later load of 0x20 returns prior contents.
REQ-036 Load 0x12 -> with DMEM_MISALIGN_CHECK_EN rsp_err=1, rdata=0; without it rdata = word at 0x10, rsp_err=0.
